transpose_buffer: RTL and testbench
===================================

TRANSPOSE_BUFFER -- requirements
Module: transpose_buffer

Interface
REQ-001 i_clk  input  1  Single clock; all state updates on its rising edge.
REQ-002 i_rst  input  1  Reset, synchronous, active-high.
REQ-003 i_valid  input  1  One row of eight row-DCT coefficients is present on i_data0..i_data7 this cycle.
REQ-004 i_data0..i_data7  input  12 each, signed  Row coefficients, index k = column position within the row.
REQ-005 o_valid  output  1  One transposed column is present on o_data0..o_data7 this cycle.
REQ-006 o_data0..o_data7  output  12 each, signed  Column coefficients, index k = source row number.
REQ-007 o_col  output  3  Column index (0..7) of the current output.
REQ-008 o_last  output  1  High with o_valid when o_col = 7.

Function
REQ-009 The block shall store two 8x8 banks of 12-bit signed words (ping-pong), bank 0 and bank 1.
REQ-010 The block shall keep a 3-bit write-row counter and a 1-bit write-bank pointer.
- On i_valid: i_dataK is written to wbank[row][K], and row increments.
- When i_valid is low, row and pointer hold; gaps between rows are allowed.
REQ-011 When i_valid writes row 7, the block shall set full[wbank], toggle the write-bank pointer, and wrap row to 0, all in the same edge.
REQ-012 The block shall keep a 1-bit read-bank pointer (reset 0), a 3-bit read-column counter and a reading flag.
REQ-013 The read machine shall be IDLE or READ.
- IDLE -> READ on the first edge where full[rbank] = 1.
- In READ, each edge registers column col of rbank onto the outputs, with o_dataK = rbank[K][col], and increments col.
- After col 7 is registered: full[rbank] is cleared, rbank toggles and col wraps to 0.
- If full of the new rbank is already set at that edge, the machine stays in READ; otherwise it returns to IDLE.
REQ-014 Latency: the first column (o_col = 0) shall be valid the cycle after the edge that writes row 7, so o_valid rises 1 cycle after the 8th accepted row.
REQ-015 Output columns of one bank shall appear on 8 consecutive cycles with no gaps, regardless of input gaps.
REQ-016 With continuous i_valid, o_valid shall stay high continuously once the first bank has filled, with no bubble between banks.
REQ-017 Data shall pass bit-exact: no rounding, scaling, sign change or saturation.
REQ-018 Outputs shall be registered. o_valid, o_col and o_last shall change only on clock edges.
REQ-019 When o_valid = 0, o_data0..o_data7 and o_col shall hold their last registered values.
REQ-020 Overwrite safety: because one read takes 8 cycles and one fill takes at least 8 accepted rows, the writer never enters a bank before its read completes; no stall or back-pressure port exists.
REQ-021 Simultaneous events shall be handled as follows:
- Row 7 of one bank and col 7 of the other bank on the same edge: set and clear act on different bank flags; both take effect.
- A set and a clear on the same bank flag cannot occur.
REQ-022 Input is accepted unconditionally, including while reading.

Reset
REQ-023 While i_rst = 1 at an edge, the block shall clear the following:
- o_valid = 0, o_last = 0, o_col = 0, o_data0..o_data7 = 0
- row = 0, col = 0, both pointers = 0, full[0] = full[1] = 0, state IDLE
REQ-024 Bank storage contents need not be cleared.
REQ-025 Reset mid-block shall discard partially written rows and any pending or in-progress column readout.
- o_valid is low the cycle after the reset edge.
- The first i_valid after reset deassertion is row 0 of bank 0.
REQ-026 i_valid asserted during reset shall be ignored.

Verification
REQ-027 Single block: 8 consecutive rows with i_dataK = 16*r + K (r = 0..7) -> starting 1 cycle after row 7, 8 consecutive cycles with o_col = c and o_dataK = 16*K + c; o_last only at c = 7; o_valid then drops.
REQ-028 Signed extremes: row 0 all -2048, row 7 all +2047, other rows 0 -> every column has o_data0 = -2048, o_data7 = 2047, all others 0.
REQ-029 Continuous stream of 4 blocks (block b adds 256*b, with values wrapped to 12-bit signed) -> o_valid high for 32 consecutive cycles and each column matches its block; no bank corruption.
REQ-030 Gapped input, one idle cycle after every row -> output burst is still 8 consecutive columns, starting 1 cycle after row 7, with correct data.
REQ-031 Reset asserted after row 4 of bank 0, then a new full block -> no output from the aborted block; the new block reads out from bank 0 with correct data.
REQ-032 Reset asserted during column 3 of a readout -> o_valid = 0 and o_col = 0 the next cycle; the next full block outputs columns 0..7 normally.

Source files
------------

// File: rtl/transpose_buffer.sv
// Ping-pong 8x8 transpose buffer: rows of 12-bit signed coefficients go in,
// columns come out, one bank filling while the other is read.
module transpose_buffer (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic signed [11:0] i_data0,
    input  logic signed [11:0] i_data1,
    input  logic signed [11:0] i_data2,
    input  logic signed [11:0] i_data3,
    input  logic signed [11:0] i_data4,
    input  logic signed [11:0] i_data5,
    input  logic signed [11:0] i_data6,
    input  logic signed [11:0] i_data7,
    output logic               o_valid,
    output logic signed [11:0] o_data0,
    output logic signed [11:0] o_data1,
    output logic signed [11:0] o_data2,
    output logic signed [11:0] o_data3,
    output logic signed [11:0] o_data4,
    output logic signed [11:0] o_data5,
    output logic signed [11:0] o_data6,
    output logic signed [11:0] o_data7,
    output logic [2:0]         o_col,
    output logic               o_last
);

    typedef enum logic {IDLE, READ} state_t;

    state_t             state, state_next;
    logic signed [11:0] mem [2][8][8];
    logic signed [11:0] din [8];
    logic signed [11:0] dout [8];
    logic [2:0]         row, col;
    logic               wbank, rbank;
    logic [1:0]         full, full_next;
    logic               rd_active;
    logic               row_done, col_done;

    assign din[0] = i_data0;
    assign din[1] = i_data1;
    assign din[2] = i_data2;
    assign din[3] = i_data3;
    assign din[4] = i_data4;
    assign din[5] = i_data5;
    assign din[6] = i_data6;
    assign din[7] = i_data7;

    assign o_data0 = dout[0];
    assign o_data1 = dout[1];
    assign o_data2 = dout[2];
    assign o_data3 = dout[3];
    assign o_data4 = dout[4];
    assign o_data5 = dout[5];
    assign o_data6 = dout[6];
    assign o_data7 = dout[7];

    assign row_done = i_valid && (row == 3'd7);
    assign col_done = rd_active && (col == 3'd7);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        rd_active  = 1'b0;
        state_next = state;
        full_next  = full;
        case (state)
            IDLE: begin
                // Column 0 is registered on the same edge that leaves IDLE.
                if (full[rbank]) begin
                    rd_active  = 1'b1;
                    state_next = READ;
                end
            end
            READ:    rd_active = 1'b1;
            default: state_next = IDLE;
        endcase
        if (col_done) begin
            state_next = full[~rbank] ? READ : IDLE;
        end
        // Set and clear always target different banks, so both may apply.
        if (row_done) begin
            full_next[wbank] = 1'b1;
        end
        if (col_done) begin
            full_next[rbank] = 1'b0;
        end
    end

    // NOTE: bank storage has no reset; the full flags alone say what is valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_valid) begin
            for (int k = 0; k < 8; k++) begin
                mem[wbank][row][k] <= din[k];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            row     <= 3'd0;
            col     <= 3'd0;
            wbank   <= 1'b0;
            rbank   <= 1'b0;
            full    <= 2'b00;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_col   <= 3'd0;
            for (int k = 0; k < 8; k++) begin
                dout[k] <= 12'sd0;
            end
        end else begin
            state <= state_next;
            full  <= full_next;
            if (i_valid) begin
                row <= row + 3'd1;
                if (row == 3'd7) begin
                    wbank <= ~wbank;
                end
            end
            if (rd_active) begin
                o_valid <= 1'b1;
                o_col   <= col;
                o_last  <= (col == 3'd7);
                for (int k = 0; k < 8; k++) begin
                    dout[k] <= mem[rbank][k][col];
                end
                col <= col + 3'd1;
                if (col == 3'd7) begin
                    rbank <= ~rbank;
                end
            end else begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_transpose_buffer.sv
// Self-checking bench for transpose_buffer: a queue-of-matrices model is
// compared against the DUT every cycle, plus literal spot checks.
module tb_transpose_buffer;

    typedef logic signed [11:0] blk_t [8][8];

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_valid;
    logic signed [11:0] i_data0, i_data1, i_data2, i_data3;
    logic signed [11:0] i_data4, i_data5, i_data6, i_data7;
    logic               o_valid;
    logic signed [11:0] o_data0, o_data1, o_data2, o_data3;
    logic signed [11:0] o_data4, o_data5, o_data6, o_data7;
    logic [2:0]         o_col;
    logic               o_last;

    int tests = 0;
    int fails = 0;

    transpose_buffer dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
        .i_data0(i_data0), .i_data1(i_data1), .i_data2(i_data2), .i_data3(i_data3),
        .i_data4(i_data4), .i_data5(i_data5), .i_data6(i_data6), .i_data7(i_data7),
        .o_valid(o_valid),
        .o_data0(o_data0), .o_data1(o_data1), .o_data2(o_data2), .o_data3(o_data3),
        .o_data4(o_data4), .o_data5(o_data5), .o_data6(o_data6), .o_data7(o_data7),
        .o_col(o_col), .o_last(o_last)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: completed blocks queue up; each edge emits the next column of
    // the oldest complete block, which was finished on an earlier edge.
    blk_t               q[$];
    blk_t               cur;
    int                 m_row = 0;
    int                 m_pos = 0;
    logic               m_valid = 1'b0;
    logic               m_last = 1'b0;
    logic [2:0]         m_col = 3'd0;
    logic signed [11:0] m_data [8];
    logic signed [11:0] in_now [8];

    always @(posedge i_clk) begin
        in_now[0] = i_data0; in_now[1] = i_data1; in_now[2] = i_data2; in_now[3] = i_data3;
        in_now[4] = i_data4; in_now[5] = i_data5; in_now[6] = i_data6; in_now[7] = i_data7;
        if (i_rst) begin
            q.delete();
            m_row = 0; m_pos = 0;
            m_valid = 1'b0; m_last = 1'b0; m_col = 3'd0;
            for (int k = 0; k < 8; k++) m_data[k] = 12'sd0;
        end else begin
            if (q.size() > 0) begin
                m_valid = 1'b1;
                m_col   = 3'(m_pos);
                m_last  = (m_pos == 7);
                for (int k = 0; k < 8; k++) m_data[k] = q[0][k][m_pos];
                m_pos++;
                if (m_pos == 8) begin
                    m_pos = 0;
                    void'(q.pop_front());
                end
            end else begin
                m_valid = 1'b0;
                m_last  = 1'b0;
            end
            if (i_valid) begin
                for (int k = 0; k < 8; k++) cur[m_row][k] = in_now[k];
                m_row++;
                if (m_row == 8) begin
                    q.push_back(cur);
                    m_row = 0;
                end
            end
        end
    end

    bit cmp_en = 1'b0;
    int run = 0;
    int last_run = 0;

    always @(negedge i_clk) begin
        if (cmp_en) begin
            check("valid", 32'(o_valid), 32'(m_valid));
            check("last", 32'(o_last), 32'(m_last));
            check("col", 32'(o_col), 32'(m_col));
            check("d0", 32'(o_data0), 32'(m_data[0]));
            check("d1", 32'(o_data1), 32'(m_data[1]));
            check("d2", 32'(o_data2), 32'(m_data[2]));
            check("d3", 32'(o_data3), 32'(m_data[3]));
            check("d4", 32'(o_data4), 32'(m_data[4]));
            check("d5", 32'(o_data5), 32'(m_data[5]));
            check("d6", 32'(o_data6), 32'(m_data[6]));
            check("d7", 32'(o_data7), 32'(m_data[7]));
            if (o_valid === 1'b1) begin
                run++;
            end else begin
                if (run > 0) last_run = run;
                run = 0;
            end
        end
    end

    logic signed [11:0] row_d [8];

    task automatic send();
        @(posedge i_clk); #1;
        i_valid = 1'b1;
        i_data0 = row_d[0]; i_data1 = row_d[1]; i_data2 = row_d[2]; i_data3 = row_d[3];
        i_data4 = row_d[4]; i_data5 = row_d[5]; i_data6 = row_d[6]; i_data7 = row_d[7];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
            i_valid = 1'b0;
        end
    endtask

    task automatic send_block(input int offset, input bit gaps);
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) row_d[k] = 12'(16 * r + k + offset);
            send();
            if (gaps) idle(1);
        end
    endtask

    // i_valid is held high through the reset edge; it must be ignored.
    task automatic do_reset(input bit wait_edge);
        if (wait_edge) begin
            @(posedge i_clk); #1;
        end
        i_rst = 1'b1;
        i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_col", 32'(o_col), 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        i_rst = 1'b0;
        i_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        i_rst = 1'b1; i_valid = 1'b0;
        i_data0 = 0; i_data1 = 0; i_data2 = 0; i_data3 = 0;
        i_data4 = 0; i_data5 = 0; i_data6 = 0; i_data7 = 0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_col", 32'(o_col), 32'd0);
        check("reset_last", 32'(o_last), 32'd0);
        check("reset_d0", 32'(o_data0), 32'd0);
        check("reset_d7", 32'(o_data7), 32'd0);
        cmp_en = 1'b1;
        i_rst = 1'b0;

        // Single block: o_dataK = 16*K + c, first column two edges after row 7 is driven.
        send_block(0, 1'b0);
        idle(1);
        @(posedge i_clk);
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            check("single_valid", 32'(o_valid), 32'd1);
            check("single_col", 32'(o_col), 32'(c));
            check("single_d5", 32'(o_data5), 32'(80 + c));
            check("single_d0", 32'(o_data0), 32'(c));
            check("single_last", 32'(o_last), 32'(c == 7));
        end
        @(negedge i_clk);
        check("single_drop", 32'(o_valid), 32'd0);
        check("single_hold_col", 32'(o_col), 32'd7);
        check("single_hold_d7", 32'(o_data7), 32'd119);
        idle(3);

        // Signed extremes.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++)
                row_d[k] = (r == 0) ? -12'sd2048 : (r == 7) ? 12'sd2047 : 12'sd0;
            send();
        end
        idle(1);
        @(posedge i_clk);
        @(negedge i_clk);
        check("ext_d0", 32'(o_data0), 32'hFFFF_F800);
        check("ext_d7", 32'(o_data7), 32'd2047);
        check("ext_d3", 32'(o_data3), 32'd0);
        idle(10);

        // Four back-to-back blocks: one unbroken 32-column burst.
        for (int b = 0; b < 4; b++) send_block(256 * b, 1'b0);
        idle(12);
        check("stream_run", 32'(last_run), 32'd32);

        // One idle cycle after every row: still an 8-column burst.
        send_block(37, 1'b1);
        idle(12);
        check("gapped_run", 32'(last_run), 32'd8);

        // Abort a half-written bank 0, then a fresh block.
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 8; k++) row_d[k] = 12'sd999;
            send();
        end
        do_reset(1'b1);
        send_block(-1000, 1'b0);
        idle(12);
        check("abort_run", 32'(last_run), 32'd8);

        // Reset in the middle of a readout.
        send_block(500, 1'b0);
        idle(1);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (o_valid === 1'b1 && o_col === 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_col3", 32'(found), 32'd1);
        do_reset(1'b0);
        send_block(-300, 1'b0);
        idle(12);
        check("after_reset_run", 32'(last_run), 32'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
